// File: rtl/rs_pkg.sv
// Shared reservation-station definitions, also used by the register-read stage
// to build operand fields (value, or ROB tag in the low bits when not ready).
package rs_pkg;

    localparam int RS_DEPTH     = 4;
    localparam int RS_TAGW      = 6;
    localparam int OPND_TAG_LSB = 0;

    // Instruction control payload carried unchanged from dispatch to issue
    typedef struct packed {
        logic [3:0]  fucontrol;
        logic [31:0] imm;
        logic [31:0] bpc;
        logic        rd_en;
    } rs_ctrl_t;

    // One source operand: den=1 means data is a value, den=0 means data holds a tag
    typedef struct packed {
        logic        den;
        logic [31:0] data;
    } rs_opnd_t;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: one-hot grant of the lowest set request bit.
module rs_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         found
);

    // Isolate the lowest set bit with the two's-complement trick
    assign grant = req & (~req + N'(1));
    assign found = |req;

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until both operands are
// values (captured from dispatch or the two CDB ports), then moves the
// lowest-index ready entry into a single registered issue slot.
module reservation_station
    import rs_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH,
    parameter int TAGW  = RS_TAGW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,

    input  logic            d1_valid,
    input  logic            d1_res_en,
    input  logic [3:0]      d1_fucontrol,
    input  logic [31:0]     d1_imm,
    input  logic [31:0]     d1_bpc,
    input  logic            d1_rd_en,
    input  logic [TAGW-1:0] d1_rd_tag,
    input  logic [31:0]     d1_rs_data,
    input  logic [31:0]     d1_rt_data,
    input  logic            d1_rs_den,
    input  logic            d1_rt_den,

    input  logic            d2_valid,
    input  logic            d2_res_en,
    input  logic [3:0]      d2_fucontrol,
    input  logic [31:0]     d2_imm,
    input  logic [31:0]     d2_bpc,
    input  logic            d2_rd_en,
    input  logic [TAGW-1:0] d2_rd_tag,
    input  logic [31:0]     d2_rs_data,
    input  logic [31:0]     d2_rt_data,
    input  logic            d2_rs_den,
    input  logic            d2_rt_den,

    input  logic            cdb1_valid,
    input  logic [TAGW-1:0] cdb1_tag,
    input  logic [31:0]     cdb1_data,
    input  logic            cdb2_valid,
    input  logic [TAGW-1:0] cdb2_tag,
    input  logic [31:0]     cdb2_data,

    output logic            disp_ready,

    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [3:0]      iss_fucontrol,
    output logic [31:0]     iss_imm,
    output logic [31:0]     iss_bpc,
    output logic            iss_rd_en,
    output logic [TAGW-1:0] iss_rd_tag,
    output logic [31:0]     iss_rs_data,
    output logic [31:0]     iss_rt_data,

    output logic [3:0]      occupancy
);

    logic [DEPTH-1:0] valid_q;
    rs_ctrl_t         ctrl_q [DEPTH];
    logic [TAGW-1:0]  tag_q  [DEPTH];
    rs_opnd_t         rs_q   [DEPTH];
    rs_opnd_t         rt_q   [DEPTH];
    logic [3:0]       occ_q;

    // Capture a CDB result into a waiting operand; cdb1 wins when both match
    function automatic rs_opnd_t resolve(
        input rs_opnd_t        op,
        input logic            c1v,
        input logic [TAGW-1:0] c1t,
        input logic [31:0]     c1d,
        input logic            c2v,
        input logic [TAGW-1:0] c2t,
        input logic [31:0]     c2d
    );
        rs_opnd_t r;
        r = op;
        if (!op.den) begin
            if (c1v && (op.data[OPND_TAG_LSB +: TAGW] == c1t)) begin
                r.den  = 1'b1;
                r.data = c1d;
            end else if (c2v && (op.data[OPND_TAG_LSB +: TAGW] == c2t)) begin
                r.den  = 1'b1;
                r.data = c2d;
            end
        end
        return r;
    endfunction

    // Dispatch-side operands with same-cycle CDB bypass applied
    rs_opnd_t d1_rs_in, d1_rt_in, d2_rs_in, d2_rt_in;
    rs_ctrl_t d1_ctrl, d2_ctrl;

    assign d1_rs_in = resolve(rs_opnd_t'({d1_rs_den, d1_rs_data}), cdb1_valid, cdb1_tag, cdb1_data,
                              cdb2_valid, cdb2_tag, cdb2_data);
    assign d1_rt_in = resolve(rs_opnd_t'({d1_rt_den, d1_rt_data}), cdb1_valid, cdb1_tag, cdb1_data,
                              cdb2_valid, cdb2_tag, cdb2_data);
    assign d2_rs_in = resolve(rs_opnd_t'({d2_rs_den, d2_rs_data}), cdb1_valid, cdb1_tag, cdb1_data,
                              cdb2_valid, cdb2_tag, cdb2_data);
    assign d2_rt_in = resolve(rs_opnd_t'({d2_rt_den, d2_rt_data}), cdb1_valid, cdb1_tag, cdb1_data,
                              cdb2_valid, cdb2_tag, cdb2_data);
    assign d1_ctrl  = rs_ctrl_t'({d1_fucontrol, d1_imm, d1_bpc, d1_rd_en});
    assign d2_ctrl  = rs_ctrl_t'({d2_fucontrol, d2_imm, d2_bpc, d2_rd_en});

    // Wakeup view of every stored operand
    rs_opnd_t rs_wk [DEPTH];
    rs_opnd_t rt_wk [DEPTH];
    logic [DEPTH-1:0] ready_vec;

    // Per-entry wakeup and readiness
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rs_wk[i]     = resolve(rs_q[i], cdb1_valid, cdb1_tag, cdb1_data,
                                   cdb2_valid, cdb2_tag, cdb2_data);
            rt_wk[i]     = resolve(rt_q[i], cdb1_valid, cdb1_tag, cdb1_data,
                                   cdb2_valid, cdb2_tag, cdb2_data);
            ready_vec[i] = valid_q[i] & rs_q[i].den & rt_q[i].den;
        end
    end

    // Free-slot selection works on registered valids; an entry freed by this
    // edge's issue load is not reused until the next cycle.
    logic [DEPTH-1:0] free_oh1, free_oh2, ready_oh, slot2_oh;
    logic             free_found1, free_found2, ready_found;

    rs_pick #(.N(DEPTH)) u_pick_free1 (
        .req   (~valid_q),
        .grant (free_oh1),
        .found (free_found1)
    );

    rs_pick #(.N(DEPTH)) u_pick_free2 (
        .req   (~valid_q & ~free_oh1),
        .grant (free_oh2),
        .found (free_found2)
    );

    rs_pick #(.N(DEPTH)) u_pick_ready (
        .req   (ready_vec),
        .grant (ready_oh),
        .found (ready_found)
    );

    logic acc1, acc2, load;

    assign disp_ready = (occ_q <= 4'(DEPTH - 2));
    assign acc1       = d1_valid & d1_res_en & disp_ready & free_found1;
    assign acc2       = d2_valid & d2_res_en & disp_ready & (acc1 ? free_found2 : free_found1);
    assign slot2_oh   = acc1 ? free_oh2 : free_oh1;
    assign load       = ready_found & (~iss_valid | iss_ready);
    assign occupancy  = occ_q;

    // Payload of the entry chosen for the issue slot
    rs_ctrl_t        sel_ctrl;
    logic [TAGW-1:0] sel_tag;
    logic [31:0]     sel_rs, sel_rt;

    always_comb begin
        sel_ctrl = '0;
        sel_tag  = '0;
        sel_rs   = '0;
        sel_rt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready_oh[i]) begin
                sel_ctrl = ctrl_q[i];
                sel_tag  = tag_q[i];
                sel_rs   = rs_q[i].data;
                sel_rt   = rt_q[i].data;
            end
        end
    end

    // Entry storage: dispatch writes, wakeup captures, issue load frees
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctrl_q[i] <= '0;
                tag_q[i]  <= '0;
                rs_q[i]   <= '0;
                rt_q[i]   <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (acc1 && free_oh1[i]) begin
                    valid_q[i] <= 1'b1;
                    ctrl_q[i]  <= d1_ctrl;
                    tag_q[i]   <= d1_rd_tag;
                    rs_q[i]    <= d1_rs_in;
                    rt_q[i]    <= d1_rt_in;
                end else if (acc2 && slot2_oh[i]) begin
                    valid_q[i] <= 1'b1;
                    ctrl_q[i]  <= d2_ctrl;
                    tag_q[i]   <= d2_rd_tag;
                    rs_q[i]    <= d2_rs_in;
                    rt_q[i]    <= d2_rt_in;
                end else begin
                    if (load && ready_oh[i]) begin
                        valid_q[i] <= 1'b0;
                    end
                    rs_q[i] <= rs_wk[i];
                    rt_q[i] <= rt_wk[i];
                end
            end
        end
    end

    // Issue slot: load when empty or being consumed, otherwise hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid     <= 1'b0;
            iss_fucontrol <= '0;
            iss_imm       <= '0;
            iss_bpc       <= '0;
            iss_rd_en     <= 1'b0;
            iss_rd_tag    <= '0;
            iss_rs_data   <= '0;
            iss_rt_data   <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (load) begin
            iss_valid     <= 1'b1;
            iss_fucontrol <= sel_ctrl.fucontrol;
            iss_imm       <= sel_ctrl.imm;
            iss_bpc       <= sel_ctrl.bpc;
            iss_rd_en     <= sel_ctrl.rd_en;
            iss_rd_tag    <= sel_tag;
            iss_rs_data   <= sel_rs;
            iss_rt_data   <= sel_rt;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

    // Occupancy tracks accepts minus loads into the issue slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_q + 4'(acc1) + 4'(acc2) - 4'(load);
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed vector table,
// hand-written corner sequences, then random traffic against a reference model.
module tb_reservation_station;

    localparam int DEPTH = 4;
    localparam int TAGW  = 6;

    logic clk = 1'b0;
    logic rst, flush;
    logic d1_valid, d1_res_en, d1_rd_en, d1_rs_den, d1_rt_den;
    logic [3:0] d1_fucontrol;
    logic [31:0] d1_imm, d1_bpc, d1_rs_data, d1_rt_data;
    logic [TAGW-1:0] d1_rd_tag;
    logic d2_valid, d2_res_en, d2_rd_en, d2_rs_den, d2_rt_den;
    logic [3:0] d2_fucontrol;
    logic [31:0] d2_imm, d2_bpc, d2_rs_data, d2_rt_data;
    logic [TAGW-1:0] d2_rd_tag;
    logic cdb1_valid, cdb2_valid;
    logic [TAGW-1:0] cdb1_tag, cdb2_tag;
    logic [31:0] cdb1_data, cdb2_data;
    logic disp_ready, iss_valid, iss_ready, iss_rd_en;
    logic [3:0] iss_fucontrol, occupancy;
    logic [31:0] iss_imm, iss_bpc, iss_rs_data, iss_rt_data;
    logic [TAGW-1:0] iss_rd_tag;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .d1_valid(d1_valid), .d1_res_en(d1_res_en), .d1_fucontrol(d1_fucontrol),
        .d1_imm(d1_imm), .d1_bpc(d1_bpc), .d1_rd_en(d1_rd_en), .d1_rd_tag(d1_rd_tag),
        .d1_rs_data(d1_rs_data), .d1_rt_data(d1_rt_data), .d1_rs_den(d1_rs_den), .d1_rt_den(d1_rt_den),
        .d2_valid(d2_valid), .d2_res_en(d2_res_en), .d2_fucontrol(d2_fucontrol),
        .d2_imm(d2_imm), .d2_bpc(d2_bpc), .d2_rd_en(d2_rd_en), .d2_rd_tag(d2_rd_tag),
        .d2_rs_data(d2_rs_data), .d2_rt_data(d2_rt_data), .d2_rs_den(d2_rs_den), .d2_rt_den(d2_rt_den),
        .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .cdb2_valid(cdb2_valid), .cdb2_tag(cdb2_tag), .cdb2_data(cdb2_data),
        .disp_ready(disp_ready), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_fucontrol(iss_fucontrol), .iss_imm(iss_imm), .iss_bpc(iss_bpc),
        .iss_rd_en(iss_rd_en), .iss_rd_tag(iss_rd_tag), .iss_rs_data(iss_rs_data),
        .iss_rt_data(iss_rt_data), .occupancy(occupancy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        d1_valid = 0; d1_res_en = 0; d1_fucontrol = 0; d1_imm = 0; d1_bpc = 0; d1_rd_en = 0;
        d1_rd_tag = 0; d1_rs_data = 0; d1_rt_data = 0; d1_rs_den = 0; d1_rt_den = 0;
        d2_valid = 0; d2_res_en = 0; d2_fucontrol = 0; d2_imm = 0; d2_bpc = 0; d2_rd_en = 0;
        d2_rd_tag = 0; d2_rs_data = 0; d2_rt_data = 0; d2_rs_den = 0; d2_rt_den = 0;
        cdb1_valid = 0; cdb1_tag = 0; cdb1_data = 0;
        cdb2_valid = 0; cdb2_tag = 0; cdb2_data = 0;
        flush = 0;
    endtask

    task automatic drive_d(input int port, input logic rsd, input logic [31:0] rs,
                           input logic rtd, input logic [31:0] rt, input logic [3:0] fuc);
        if (port == 1) begin
            d1_valid = 1; d1_res_en = 1; d1_fucontrol = fuc; d1_imm = rs + 1; d1_bpc = rt + 2;
            d1_rd_en = 1; d1_rd_tag = TAGW'(fuc); d1_rs_den = rsd; d1_rs_data = rs;
            d1_rt_den = rtd; d1_rt_data = rt;
        end else begin
            d2_valid = 1; d2_res_en = 1; d2_fucontrol = fuc; d2_imm = rs + 1; d2_bpc = rt + 2;
            d2_rd_en = 1; d2_rd_tag = TAGW'(fuc); d2_rs_den = rsd; d2_rs_data = rs;
            d2_rt_den = rtd; d2_rt_data = rt;
        end
    endtask

    typedef struct {
        int          port;
        logic        rsd;
        logic [31:0] rs;
        logic        rtd;
        logic [31:0] rt;
        logic        c1v;
        logic [5:0]  c1t;
        logic [31:0] c1d;
        logic        c2v;
        logic [5:0]  c2t;
        logic [31:0] c2d;
        logic [31:0] ers;
        logic [31:0] ert;
    } vec_t;

    vec_t tbl [6];

    // ---------------- reference model ----------------
    logic        m_v   [DEPTH];
    logic        m_rsd [DEPTH];
    logic        m_rtd [DEPTH];
    logic [31:0] m_rs  [DEPTH];
    logic [31:0] m_rt  [DEPTH];
    logic [74:0] m_pl  [DEPTH];
    logic        m_iv;
    logic [31:0] m_irs, m_irt;
    logic [74:0] m_ipl;

    function automatic logic [32:0] wake(input logic den, input logic [31:0] d);
        if (den) return {1'b1, d};
        if (cdb1_valid && d[TAGW-1:0] == cdb1_tag) return {1'b1, cdb1_data};
        if (cdb2_valid && d[TAGW-1:0] == cdb2_tag) return {1'b1, cdb2_data};
        return {1'b0, d};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
        m_iv = 0; m_irs = 0; m_irt = 0; m_ipl = 0;
    endtask

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m_v[i]) c++;
        return c;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    task automatic model_step();
        logic taken [DEPTH];
        int   cnt, sel, f;
        bit   found, can_load, a1, a2;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
            m_iv = 0;
            return;
        end
        cnt = model_count();
        found = 0; sel = 0;
        for (int i = 0; i < DEPTH; i++)
            if (!found && m_v[i] && m_rsd[i] && m_rtd[i]) begin found = 1; sel = i; end
        can_load = !m_iv || iss_ready;
        for (int i = 0; i < DEPTH; i++) taken[i] = m_v[i];
        if (m_iv && iss_ready) m_iv = 0;
        if (found && can_load) begin
            m_iv = 1; m_irs = m_rs[sel]; m_irt = m_rt[sel]; m_ipl = m_pl[sel]; m_v[sel] = 0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            {m_rsd[i], m_rs[i]} = wake(m_rsd[i], m_rs[i]);
            {m_rtd[i], m_rt[i]} = wake(m_rtd[i], m_rt[i]);
        end
        a1 = d1_valid && d1_res_en && (cnt <= DEPTH - 2);
        a2 = d2_valid && d2_res_en && (cnt <= DEPTH - 2);
        if (a1) begin
            f = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (!taken[i]) f = i;
            if (f >= 0) begin
                taken[f] = 1; m_v[f] = 1;
                {m_rsd[f], m_rs[f]} = wake(d1_rs_den, d1_rs_data);
                {m_rtd[f], m_rt[f]} = wake(d1_rt_den, d1_rt_data);
                m_pl[f] = {d1_fucontrol, d1_imm, d1_bpc, d1_rd_en, d1_rd_tag};
            end
        end
        if (a2) begin
            f = -1;
            for (int i = DEPTH - 1; i >= 0; i--) if (!taken[i]) f = i;
            if (f >= 0) begin
                taken[f] = 1; m_v[f] = 1;
                {m_rsd[f], m_rs[f]} = wake(d2_rs_den, d2_rs_data);
                {m_rtd[f], m_rt[f]} = wake(d2_rt_den, d2_rt_data);
                m_pl[f] = {d2_fucontrol, d2_imm, d2_bpc, d2_rd_en, d2_rd_tag};
            end
        end
    endtask

    function automatic logic [31:0] rnd_opnd(input logic den);
        logic [31:0] r;
        r = $urandom;
        if (!den) r = (r & 32'hFFFF_FFC0) | 32'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1;
        iss_ready = 1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_occ", occupancy, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_payload", {iss_fucontrol, iss_imm, iss_bpc, iss_rd_en, iss_rd_tag, iss_rs_data, iss_rt_data}, 0);
        rst = 0;

        // Directed table: single dispatch, expected issue two cycles later
        tbl[0] = '{1, 1'b1, 32'd5,          1'b1, 32'd7,  1'b0, 6'd0,  32'h0,        1'b0, 6'd0, 32'h0,  32'd5,        32'd7};
        tbl[1] = '{1, 1'b1, 32'h100,        1'b0, 32'd9,  1'b0, 6'd0,  32'h0,        1'b1, 6'd9, 32'h55, 32'h100,      32'h55};
        tbl[2] = '{1, 1'b0, 32'd3,          1'b1, 32'd1,  1'b1, 6'd3,  32'h11,       1'b1, 6'd3, 32'h22, 32'h11,       32'd1};
        tbl[3] = '{2, 1'b0, 32'd4,          1'b0, 32'd5,  1'b1, 6'd5,  32'hBB,       1'b1, 6'd4, 32'hAA, 32'hAA,       32'hBB};
        tbl[4] = '{1, 1'b1, 32'h3F,         1'b1, 32'd2,  1'b1, 6'h3F, 32'h99,       1'b0, 6'd0, 32'h0,  32'h3F,       32'd2};
        tbl[5] = '{2, 1'b0, 32'hFFFF_FF47,  1'b1, 32'd6,  1'b1, 6'd7,  32'h77,       1'b0, 6'd0, 32'h0,  32'h77,       32'd6};

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle();
            drive_d(tbl[i].port, tbl[i].rsd, tbl[i].rs, tbl[i].rtd, tbl[i].rt, 4'(i + 1));
            cdb1_valid = tbl[i].c1v; cdb1_tag = tbl[i].c1t; cdb1_data = tbl[i].c1d;
            cdb2_valid = tbl[i].c2v; cdb2_tag = tbl[i].c2t; cdb2_data = tbl[i].c2d;
            @(negedge clk);
            idle();
            chk($sformatf("vec%0d_occ_n1", i), occupancy, 1);
            chk($sformatf("vec%0d_iss_valid_n1", i), iss_valid, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_iss_valid_n2", i), iss_valid, 1);
            chk($sformatf("vec%0d_rs", i), iss_rs_data, tbl[i].ers);
            chk($sformatf("vec%0d_rt", i), iss_rt_data, tbl[i].ert);
            chk($sformatf("vec%0d_fuc", i), iss_fucontrol, 4'(i + 1));
            chk($sformatf("vec%0d_occ_n2", i), occupancy, 0);
            @(negedge clk);
            chk($sformatf("vec%0d_drained", i), iss_valid, 0);
        end

        // Wakeup two cycles after dispatch
        @(negedge clk);
        drive_d(1, 1'b0, 32'h0000_000C, 1'b1, 32'd1, 4'hA);
        @(negedge clk);
        idle();
        chk("wake_occ", occupancy, 1);
        chk("wake_wait0", iss_valid, 0);
        @(negedge clk);
        cdb1_valid = 1; cdb1_tag = 6'd12; cdb1_data = 32'hDEAD_BEEF;
        chk("wake_wait1", iss_valid, 0);
        @(negedge clk);
        idle();
        chk("wake_wait2", iss_valid, 0);
        @(negedge clk);
        chk("wake_iss_valid", iss_valid, 1);
        chk("wake_rs", iss_rs_data, 32'hDEAD_BEEF);
        chk("wake_occ0", occupancy, 0);
        @(negedge clk);

        // Fill with issue stalled, overflow dispatch ignored, payload held
        iss_ready = 0;
        drive_d(1, 1'b1, 32'hA, 1'b1, 32'd0, 4'd1);
        drive_d(2, 1'b1, 32'hB, 1'b1, 32'd0, 4'd2);
        @(negedge clk);
        chk("fill_occ2", occupancy, 2);
        chk("fill_dr2", disp_ready, 1);
        drive_d(1, 1'b1, 32'hC, 1'b1, 32'd0, 4'd3);
        drive_d(2, 1'b1, 32'hD, 1'b1, 32'd0, 4'd4);
        @(negedge clk);
        idle();
        chk("fill_occ3", occupancy, 3);
        chk("fill_dr0", disp_ready, 0);
        chk("fill_iss_a", iss_rs_data, 32'hA);
        drive_d(1, 1'b1, 32'hE, 1'b1, 32'd0, 4'd5);
        @(negedge clk);
        idle();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold%0d_valid", k), iss_valid, 1);
            chk($sformatf("hold%0d_rs", k), iss_rs_data, 32'hA);
            chk($sformatf("hold%0d_occ", k), occupancy, 3);
            @(negedge clk);
        end
        iss_ready = 1;
        @(negedge clk);
        chk("drain_b", iss_rs_data, 32'hB);
        chk("drain_b_occ", occupancy, 2);
        @(negedge clk);
        chk("drain_c", iss_rs_data, 32'hC);
        @(negedge clk);
        chk("drain_d", iss_rs_data, 32'hD);
        chk("drain_d_occ", occupancy, 0);
        @(negedge clk);
        chk("drain_empty", iss_valid, 0);

        // Flush overriding simultaneous dispatch
        drive_d(1, 1'b1, 32'h21, 1'b1, 32'd0, 4'd1);
        drive_d(2, 1'b1, 32'h22, 1'b1, 32'd0, 4'd2);
        @(negedge clk);
        flush = 1;
        drive_d(1, 1'b1, 32'h23, 1'b1, 32'd0, 4'd3);
        drive_d(2, 1'b1, 32'h24, 1'b1, 32'd0, 4'd4);
        @(negedge clk);
        idle();
        chk("flush_occ", occupancy, 0);
        chk("flush_iss_valid", iss_valid, 0);
        chk("flush_dr", disp_ready, 1);
        @(negedge clk);
        chk("flush_iss_valid2", iss_valid, 0);

        // Asynchronous reset between edges
        iss_ready = 0;
        drive_d(1, 1'b1, 32'h31, 1'b1, 32'd0, 4'd1);
        drive_d(2, 1'b1, 32'h32, 1'b1, 32'd0, 4'd2);
        @(negedge clk);
        idle();
        @(negedge clk);
        chk("arst_pre_valid", iss_valid, 1);
        chk("arst_pre_occ", occupancy, 1);
        #1 rst = 1;
        #1;
        chk("arst_iss_valid", iss_valid, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_rs", iss_rs_data, 0);
        #1 rst = 0;
        @(negedge clk);
        @(negedge clk);
        chk("arst_after", iss_valid, 0);
        iss_ready = 1;

        // Random traffic against the reference model
        rst = 1;
        idle();
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            chk("rnd_occ", occupancy, model_count());
            chk("rnd_disp_ready", disp_ready, model_count() <= DEPTH - 2);
            chk("rnd_iss_valid", iss_valid, m_iv);
            if (m_iv) begin
                chk("rnd_payload", {iss_fucontrol, iss_imm, iss_bpc, iss_rd_en, iss_rd_tag}, m_ipl);
                chk("rnd_rs", iss_rs_data, m_irs);
                chk("rnd_rt", iss_rt_data, m_irt);
            end
            d1_valid = $urandom_range(0, 3) != 0;  d1_res_en = $urandom_range(0, 3) != 0;
            d1_fucontrol = 4'($urandom); d1_imm = $urandom; d1_bpc = $urandom;
            d1_rd_en = 1'($urandom); d1_rd_tag = TAGW'($urandom);
            d1_rs_den = 1'($urandom); d1_rs_data = rnd_opnd(d1_rs_den);
            d1_rt_den = 1'($urandom); d1_rt_data = rnd_opnd(d1_rt_den);
            d2_valid = $urandom_range(0, 3) != 0;  d2_res_en = $urandom_range(0, 3) != 0;
            d2_fucontrol = 4'($urandom); d2_imm = $urandom; d2_bpc = $urandom;
            d2_rd_en = 1'($urandom); d2_rd_tag = TAGW'($urandom);
            d2_rs_den = 1'($urandom); d2_rs_data = rnd_opnd(d2_rs_den);
            d2_rt_den = 1'($urandom); d2_rt_data = rnd_opnd(d2_rt_den);
            cdb1_valid = 1'($urandom); cdb1_tag = TAGW'($urandom_range(0, 7)); cdb1_data = $urandom;
            cdb2_valid = 1'($urandom); cdb2_tag = TAGW'($urandom_range(0, 7)); cdb2_data = $urandom;
            iss_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 49) == 0;
            model_step();
        end
        @(negedge clk);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter DEPTH, default 4, is the number of entries; legal range 4..8.
REQ-002 Parameter TAGW, default 6, is the ROB tag width; equals the physical-register number width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  discards all entries and the issue slot.
REQ-006 dN_valid, dN_res_en  input  1 each (N=1,2)  dispatch request; an instruction is accepted only when both are high and disp_ready=1.
REQ-007 dN_fucontrol 4 / dN_imm 32 / dN_bpc 32 / dN_rd_en 1 / dN_rd_tag TAGW  input  instruction payload.
REQ-008 dN_rs_data, dN_rt_data  input  32  operand value, or tag in bits [TAGW-1:0] when not ready.
REQ-009 dN_rs_den, dN_rt_den  input  1  operand ready (1 = value, 0 = tag).
REQ-010 cdbM_valid 1 / cdbM_tag TAGW / cdbM_data 32  input  (M=1,2)  result broadcast.
REQ-011 disp_ready  output  1  both dispatch ports can be accepted this cycle.
REQ-012 iss_valid  output  1;  iss_ready  input  1  issue handshake.
REQ-013 iss_fucontrol 4 / iss_imm 32 / iss_bpc 32 / iss_rd_en 1 / iss_rd_tag TAGW / iss_rs_data 32 / iss_rt_data 32  output  issued payload.
REQ-014 occupancy  output  4  count of valid entries (issue slot excluded).

Function
REQ-015 Each entry SHALL hold valid, payload, and per-operand den/data.
REQ-016 disp_ready SHALL be 1 iff occupancy <= DEPTH-2, computed from registered state only.
REQ-017 Accepted d1 SHALL take the lowest-index free entry; d2 the next lowest; lone d2 takes the lowest.
REQ-018 Wakeup: each cycle, every valid entry operand with den=0 whose stored tag equals a valid cdbM_tag SHALL capture cdbM_data and set den=1.
REQ-019 Dispatch bypass: an operand dispatched with den=0 matching a same-cycle valid CDB tag SHALL be written with CDB data and den=1.
REQ-020 If both CDB ports match one operand, cdb1 SHALL win.
REQ-021 An entry is ready when valid and both den=1; operands an instruction does not use arrive with den=1.
REQ-022 Issue slot is a single register; it SHALL load the lowest-index ready entry when empty or when iss_valid&iss_ready, freeing that entry in the same edge.
REQ-023 Issue-slot outputs SHALL stay stable while iss_valid=1 and iss_ready=0.
REQ-024 Minimum latency: dispatch with both operands ready in cycle N -> iss_valid=1 in cycle N+2.
REQ-025 Occupancy SHALL update by +accepts -loads into issue slot in the same edge.
REQ-026 flush SHALL clear every entry valid and iss_valid at the next edge, overriding dispatch, wakeup and load in that cycle.
REQ-027 Dispatch while disp_ready=0 SHALL be ignored without state change.

Reset
REQ-028 On rst all entry valid bits, iss_valid and occupancy SHALL be 0; disp_ready SHALL be 1; iss payload outputs SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL drop all held instructions immediately, without waiting for a clock edge.

Structure
REQ-030 DEPTH and TAGW defaults, and the operand tag-field position, SHALL live in shared package rs_pkg, reused by the register-read stage.
REQ-031 One sub-module rs_pick SHALL supply the lowest-index priority encoder (one-hot + found flag), instantiated for free-slot selection (x2) and ready selection.

Verification
REQ-032 Reset, then dispatch d1 with rs=5/den=1 and rt=7/den=1, iss_ready=1 -> iss_valid in cycle N+2, iss_rs_data=5, iss_rt_data=7, occupancy back to 0.
REQ-033 Dispatch d1 with rs_den=0, rs_data=0x0000000C; cdb1 tag=12, data=0xDEADBEEF two cycles later -> issue with iss_rs_data=0xDEADBEEF.
REQ-034 Dispatch with rt tag 9, cdb2 tag=9, data=0x55 in the same cycle -> bypass captured, issue at N+2 with iss_rt_data=0x55.
REQ-035 Fill DEPTH=4 with iss_ready=0 -> disp_ready=0 at occupancy 3; a further dispatch is ignored; issue payload held stable for 5 cycles.
REQ-036 Both cdb1 and cdb2 carry tag 3 (data 0x11 and 0x22) -> operand captures 0x11.
REQ-037 flush asserted together with two dispatches -> next cycle occupancy=0, iss_valid=0, disp_ready=1; an async rst pulse between edges clears iss_valid without a clock edge.
